uart_boot_loader: RTL and testbench



---
 rtl/uart_boot_loader_if.sv | 30 +++
 rtl/uart_boot_loader.sv | 185 ++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_boot_loader_if.sv
// Signals between the boot loader and its neighbours: board switch, buart receiver, j1 memory/UART strobes, RAM port A.
interface uart_boot_loader_if #(
   parameter int unsigned ADDR_W = 12
);
   logic              boot_req;
   logic              uart_valid;
   logic [7:0]        uart_data;
   logic              uart_rd;
   logic              cpu_uart_rd;
   logic [15:0]       cpu_addr;
   logic [15:0]       cpu_d;
   logic              cpu_wr;
   logic [ADDR_W-1:0] ram_addr;
   logic [15:0]       ram_d;
   logic              ram_wr;
   logic              cpu_resetq;
   logic              busy;
   logic              done;
   logic              err;

   modport slave (
      input  boot_req, uart_valid, uart_data, cpu_uart_rd, cpu_addr, cpu_d, cpu_wr,
      output uart_rd, ram_addr, ram_d, ram_wr, cpu_resetq, busy, done, err
   );

   modport master (
      output boot_req, uart_valid, uart_data, cpu_uart_rd, cpu_addr, cpu_d, cpu_wr,
      input  uart_rd, ram_addr, ram_d, ram_wr, cpu_resetq, busy, done, err
   );
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot sequencer owning RAM port A during a session, transparent CPU mux otherwise; LOADER_CSUM_EN adds a trailing checksum byte.
// IDLE passthrough is zero latency; one byte per two cycles at most, stalls while uart_valid is low and errors after TIMEOUT idle cycles.
module uart_boot_loader #(
   parameter int unsigned ADDR_W  = 12,
   parameter logic [7:0]  SYNC    = 8'hA5,
   parameter int unsigned TIMEOUT = 50_000_000
) (
   input  logic              clk,
   input  logic              resetq,
   uart_boot_loader_if.slave bus
);
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      ST_IDLE, ST_SYNC, ST_LEN_H, ST_LEN_L, ST_DAT_H, ST_DAT_L, ST_CSUM, ST_FINISH, ST_ERROR
   } state_t;

`ifdef LOADER_CSUM_EN
   localparam state_t ST_AFTER_DATA = ST_CSUM;
`else
   localparam state_t ST_AFTER_DATA = ST_FINISH;
`endif

   state_t            state_q, state_d;
   logic              gap_q, gap_d;
   logic [7:0]        byte_q, byte_d;
   logic [7:0]        hi_q, hi_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              err_q, err_d;
   logic              sync1_q, sync2_q, prev_q;
`ifdef LOADER_CSUM_EN
   logic [7:0]        sum_q, sum_d;
`endif

   logic        boot_edge;
   logic        start;
   logic [15:0] len_w;
   logic        unused_addr_bits;

   assign boot_edge        = sync2_q & ~prev_q;
   assign len_w            = {cnt_q[15:8], byte_q};
   assign bus.err          = err_q;
   assign unused_addr_bits = ^{bus.cpu_addr[15:ADDR_W+1], bus.cpu_addr[0]};

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      byte_d  = byte_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
`ifdef LOADER_CSUM_EN
      sum_d   = sum_q;
`endif
      start          = 1'b0;
      bus.uart_rd    = 1'b0;
      bus.ram_addr   = ptr_q;
      bus.ram_d      = {hi_q, byte_q};
      bus.ram_wr     = 1'b0;
      bus.cpu_resetq = 1'b0;
      bus.busy       = 1'b1;
      bus.done       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Strobes are gated by resetq so nothing leaks to RAM/UART while the board is held in reset.
            bus.busy       = 1'b0;
            bus.cpu_resetq = resetq;
            bus.ram_addr   = bus.cpu_addr[ADDR_W:1];
            bus.ram_d      = bus.cpu_d;
            bus.ram_wr     = bus.cpu_wr & resetq;
            bus.uart_rd    = bus.cpu_uart_rd & resetq;
            start          = boot_edge;
         end
         ST_ERROR:  start = boot_edge;
         ST_FINISH: begin
            bus.done = 1'b1;
            state_d  = ST_IDLE;
         end
         default: begin
            tmo_d = tmo_q + 1'b1;
            if (gap_q) begin
               // The latched byte is acted on in the gap cycle, so RAM writes land one cycle after the read strobe.
               gap_d = 1'b0;
               case (state_q)
                  ST_SYNC:  if (byte_q == SYNC) state_d = ST_LEN_H;
                  ST_LEN_H: begin
                     cnt_d   = {byte_q, 8'h00};
                     state_d = ST_LEN_L;
                  end
                  ST_LEN_L: begin
                     cnt_d   = len_w;
                     state_d = (len_w == 16'd0) ? ST_AFTER_DATA : ST_DAT_H;
                  end
                  ST_DAT_H: begin
                     hi_d    = byte_q;
                     state_d = ST_DAT_L;
                  end
                  ST_DAT_L: begin
                     bus.ram_wr = 1'b1;
                     ptr_d      = ptr_q + 1'b1;
                     cnt_d      = cnt_q - 16'd1;
                     state_d    = (cnt_q == 16'd1) ? ST_AFTER_DATA : ST_DAT_H;
                  end
`ifdef LOADER_CSUM_EN
                  ST_CSUM: begin
                     if (byte_q == sum_q) begin
                        state_d = ST_FINISH;
                     end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                     end
                  end
`endif
                  default: state_d = state_q;
               endcase
            end else if (bus.uart_valid) begin
               bus.uart_rd = 1'b1;
               byte_d      = bus.uart_data;
               gap_d       = 1'b1;
               tmo_d       = '0;
            end else if (tmo_q == TMO_LAST) begin
               state_d = ST_ERROR;
               err_d   = 1'b1;
            end
         end
      endcase

`ifdef LOADER_CSUM_EN
      if (gap_q && (state_q inside {ST_LEN_H, ST_LEN_L, ST_DAT_H, ST_DAT_L}))
         sum_d = sum_q + byte_q;
`endif

      if (start) begin
         state_d = ST_SYNC;
         err_d   = 1'b0;
         ptr_d   = '0;
         cnt_d   = '0;
         tmo_d   = '0;
         gap_d   = 1'b0;
`ifdef LOADER_CSUM_EN
         sum_d   = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state_q <= ST_IDLE;
         gap_q   <= 1'b0;
         byte_q  <= '0;
         hi_q    <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
`ifdef LOADER_CSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         byte_q  <= byte_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         sync1_q <= bus.boot_req;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
`ifdef LOADER_CSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: passthrough vector table plus boot, junk, timeout, error-recovery and reset sequences.
module tb_uart_boot_loader;
   localparam int unsigned AW = 12;

   logic clk = 1'b0;
   logic resetq;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   n_wr   = 0;
   int   n_done = 0;
   int   wr0, done0;
   logic [15:0] mem [0:(1<<AW)-1];

   typedef struct {
      logic [15:0] addr;
      logic [15:0] d;
      logic        wr;
      logic        urd;
      logic [11:0] exp_addr;
      logic        exp_wr;
      logic        exp_urd;
   } vec_t;
   vec_t vecs [4];

   uart_boot_loader_if #(.ADDR_W(AW)) bus ();

   uart_boot_loader #(.ADDR_W(AW), .SYNC(8'hA5), .TIMEOUT(100)) dut (
      .clk    (clk),
      .resetq (resetq),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.busy && bus.ram_wr) begin
         mem[bus.ram_addr] <= bus.ram_d;
         n_wr <= n_wr + 1;
      end
      if (bus.done) n_done <= n_done + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit got = 1'b0;
      @(negedge clk);
      bus.uart_valid = 1'b1;
      bus.uart_data  = b;
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if (bus.uart_rd) got = 1'b1;
         @(negedge clk);
      end
      bus.uart_valid = 1'b0;
      chk("uart_rd_seen", got, 1'b1);
   endtask

   task automatic send_image(input logic [15:0] n, input logic [15:0] w0, input logic [15:0] w1,
                             input logic [7:0] bad);
      logic [7:0] s;
      s = n[15:8] + n[7:0];
      send_byte(8'hA5);
      send_byte(n[15:8]);
      send_byte(n[7:0]);
      if (n > 0) begin
         send_byte(w0[15:8]);
         send_byte(w0[7:0]);
         s = s + w0[15:8] + w0[7:0];
      end
      if (n > 1) begin
         send_byte(w1[15:8]);
         send_byte(w1[7:0]);
         s = s + w1[15:8] + w1[7:0];
      end
`ifdef LOADER_CSUM_EN
      send_byte(s + bad);
`endif
   endtask

   task automatic boot(input bit from_idle);
      @(negedge clk);
      bus.boot_req = 1'b1;
      @(posedge clk); #1;
      if (from_idle) chk("boot_lat1", bus.cpu_resetq, 1'b1);
      @(posedge clk); #1;
      if (from_idle) chk("boot_lat2", bus.cpu_resetq, 1'b1);
      @(posedge clk); #1;
      chk("boot_cpu_held", bus.cpu_resetq, 1'b0);
      chk("boot_busy", bus.busy, 1'b1);
      chk("boot_err_clr", bus.err, 1'b0);
      bus.boot_req = 1'b0;
   endtask

   initial begin
      vecs[0] = '{16'h0024, 16'hBEEF, 1'b1, 1'b0, 12'h012, 1'b1, 1'b0};
      vecs[1] = '{16'h1FFE, 16'h1234, 1'b0, 1'b1, 12'hFFF, 1'b0, 1'b1};
      vecs[2] = '{16'hF00A, 16'h0000, 1'b1, 1'b1, 12'h805, 1'b1, 1'b1};
      vecs[3] = '{16'h0001, 16'hFFFF, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};

      resetq          = 1'b0;
      bus.boot_req    = 1'b0;
      bus.uart_valid  = 1'b0;
      bus.uart_data   = 8'h00;
      bus.cpu_uart_rd = 1'b1;
      bus.cpu_addr    = 16'h0024;
      bus.cpu_d       = 16'hBEEF;
      bus.cpu_wr      = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ram_wr", bus.ram_wr, 1'b0);
      chk("rst_uart_rd", bus.uart_rd, 1'b0);
      chk("rst_cpu_resetq", bus.cpu_resetq, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      resetq = 1'b1;
      #1 chk("rel_cpu_resetq", bus.cpu_resetq, 1'b1);

      // Idle passthrough table
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.cpu_addr    = vecs[i].addr;
         bus.cpu_d       = vecs[i].d;
         bus.cpu_wr      = vecs[i].wr;
         bus.cpu_uart_rd = vecs[i].urd;
         #1;
         chk("pt_ram_addr", bus.ram_addr, vecs[i].exp_addr);
         chk("pt_ram_d", bus.ram_d, vecs[i].d);
         chk("pt_ram_wr", bus.ram_wr, vecs[i].exp_wr);
         chk("pt_uart_rd", bus.uart_rd, vecs[i].exp_urd);
      end
      @(negedge clk);
      bus.cpu_wr      = 1'b0;
      bus.cpu_uart_rd = 1'b0;

      // Good load of two words; CPU strobes must be ignored during the session
      wr0 = n_wr; done0 = n_done;
      boot(1'b1);
      bus.cpu_wr = 1'b1;
      send_image(16'd2, 16'h1234, 16'hABCD, 8'd0);
`ifndef LOADER_CSUM_EN
      #1;
      chk("gap_ram_wr", bus.ram_wr, 1'b1);
      chk("gap_ram_addr", bus.ram_addr, 12'h001);
      chk("gap_ram_d", bus.ram_d, 16'hABCD);
`endif
      @(negedge clk);
      chk("good_done", bus.done, 1'b1);
      chk("good_fin_held", bus.cpu_resetq, 1'b0);
      bus.cpu_wr = 1'b0;
      @(negedge clk);
      chk("good_done_1cyc", bus.done, 1'b0);
      chk("good_cpu_run", bus.cpu_resetq, 1'b1);
      chk("good_busy", bus.busy, 1'b0);
      chk("good_err", bus.err, 1'b0);
      chk("good_mem0", mem[0], 16'h1234);
      chk("good_mem1", mem[1], 16'hABCD);
      chk("good_nwr", n_wr - wr0, 2);

`ifdef LOADER_CSUM_EN
      // Bad checksum, then recovery with a good frame
      done0 = n_done;
      boot(1'b1);
      send_image(16'd2, 16'h1234, 16'hABCD, 8'd1);
      repeat (3) @(negedge clk);
      chk("badcs_err", bus.err, 1'b1);
      chk("badcs_held", bus.cpu_resetq, 1'b0);
      chk("badcs_nodone", n_done - done0, 0);
      boot(1'b0);
      send_image(16'd1, 16'hC0DE, 16'h0000, 8'd0);
      repeat (3) @(negedge clk);
      chk("badcs_recover_mem", mem[0], 16'hC0DE);
      chk("badcs_recover_run", bus.cpu_resetq, 1'b1);
`endif

      // Junk bytes before sync
      wr0 = n_wr; done0 = n_done;
      boot(1'b1);
      send_byte(8'h00);
      send_byte(8'hFF);
      chk("junk_still_busy", bus.busy, 1'b1);
      send_image(16'd1, 16'h55AA, 16'h0000, 8'd0);
      repeat (3) @(negedge clk);
      chk("junk_mem0", mem[0], 16'h55AA);
      chk("junk_done", n_done - done0, 1);
      chk("junk_nwr", n_wr - wr0, 1);
      chk("junk_err", bus.err, 1'b0);

      // Zero-length image
      wr0 = n_wr; done0 = n_done;
      boot(1'b1);
      send_image(16'd0, 16'h0000, 16'h0000, 8'd0);
      repeat (3) @(negedge clk);
      chk("n0_done", n_done - done0, 1);
      chk("n0_nwr", n_wr - wr0, 0);
      chk("n0_run", bus.cpu_resetq, 1'b1);

      // Timeout after LEN_H, then recovery
      wr0 = n_wr; done0 = n_done;
      boot(1'b1);
      send_byte(8'hA5);
      send_byte(8'h00);
      repeat (99) @(posedge clk);
      #1 chk("tmo_err_99", bus.err, 1'b0);
      @(posedge clk);
      #1 chk("tmo_err_100", bus.err, 1'b1);
      chk("tmo_held", bus.cpu_resetq, 1'b0);
      repeat (10) @(negedge clk);
      chk("tmo_err_sticky", bus.err, 1'b1);
      chk("tmo_nodone", n_done - done0, 0);
      chk("tmo_nwr", n_wr - wr0, 0);
      boot(1'b0);
      send_image(16'd2, 16'h0F0F, 16'h7001, 8'd0);
      repeat (3) @(negedge clk);
      chk("tmo_rec_mem0", mem[0], 16'h0F0F);
      chk("tmo_rec_mem1", mem[1], 16'h7001);
      chk("tmo_rec_run", bus.cpu_resetq, 1'b1);
      chk("tmo_rec_err", bus.err, 1'b0);

      // Reset asserted while waiting for the first data byte
      boot(1'b1);
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h02);
      @(negedge clk);
      bus.cpu_wr = 1'b1;
      resetq     = 1'b0;
      #1;
      chk("mrst_busy", bus.busy, 1'b0);
      chk("mrst_ram_wr", bus.ram_wr, 1'b0);
      chk("mrst_cpu_resetq", bus.cpu_resetq, 1'b0);
      @(negedge clk);
      resetq = 1'b1;
      #1;
      chk("mrst_rel_cpu", bus.cpu_resetq, 1'b1);
      chk("mrst_rel_idle", bus.busy, 1'b0);
      chk("mrst_rel_pt_wr", bus.ram_wr, 1'b1);
      @(negedge clk);
      bus.cpu_wr = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
